// File: rtl/decode_stage.sv
// Registered ID stage: field decode, immediates and PC-relative target, LM/SM micro-op sequencer.
// Optional illegal-opcode flag output is enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_pc,
  input  logic [WIDTH-1:0]  in_ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_pc,
  output logic [WIDTH-1:0]  out_ir,
  output logic [WIDTH-1:0]  pc_imm,
  output logic [WIDTH-1:0]  sext_out,
  output logic [WIDTH-1:0]  imm970,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  output logic [REG_AW-1:0] wa,
  output logic              wr_en,
  output logic              uop_last,
  output logic [REG_AW:0]   uop_offset
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_MULTI = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_pc_q, out_pc_d, out_ir_q, out_ir_d;
  logic [WIDTH-1:0] pc_imm_q, pc_imm_d, sext_q, sext_d, imm970_q, imm970_d;
  logic [REG_AW-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic             wr_en_q, wr_en_d, uop_last_q, uop_last_d, illegal_q, illegal_d;
  logic [REG_AW:0]  uop_offset_q, uop_offset_d;

  logic [3:0]        opc, cur_opc;
  logic              in_xfer, out_xfer, is_multi, dec_wr_en, dec_illegal;
  logic [REG_AW-1:0] dec_wa, bit_idx;
  logic [NREGS-1:0]  mask_src, mask_rem;

  function automatic logic [REG_AW-1:0] lowest_idx(input logic [NREGS-1:0] m);
    lowest_idx = '0;
    for (int k = NREGS - 1; k >= 0; k--) begin
      if (m[k]) lowest_idx = k[REG_AW-1:0];
    end
  endfunction

  assign in_ready = !reset && !flush && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  assign opc      = in_ir[WIDTH-1:WIDTH-4];
  assign cur_opc  = out_ir_q[WIDTH-1:WIDTH-4];
  assign is_multi = (opc == 4'b0110) || (opc == 4'b0111);

  // One priority encoder serves both the first micro-op (from IR) and the rest (from the mask).
  assign mask_src = (state_q == S_MULTI) ? mask_q : in_ir[NREGS-1:0];
  assign bit_idx  = lowest_idx(mask_src);
  assign mask_rem = mask_src & ~({{(NREGS-1){1'b0}}, 1'b1} << bit_idx);

  always_comb begin
    dec_wa      = '0;
    dec_wr_en   = 1'b0;
    dec_illegal = 1'b0;
    case (opc)
      4'b0000, 4'b0010:                   begin dec_wa = in_ir[5:3];  dec_wr_en = 1'b1; end
      4'b0001:                            begin dec_wa = in_ir[8:6];  dec_wr_en = 1'b1; end
      4'b0011, 4'b0100, 4'b1000, 4'b1001: begin dec_wa = in_ir[11:9]; dec_wr_en = 1'b1; end
      4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111: dec_illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_ir_d     = out_ir_q;
    pc_imm_d     = pc_imm_q;
    sext_d       = sext_q;
    imm970_d     = imm970_q;
    ra1_d        = ra1_q;
    ra2_d        = ra2_q;
    wa_d         = wa_q;
    wr_en_d      = wr_en_q;
    uop_last_d   = uop_last_q;
    uop_offset_d = uop_offset_q;
    illegal_d    = illegal_q;

    if (out_xfer) out_valid_d = 1'b0;

    if (state_q == S_MULTI && out_xfer) begin
      out_valid_d  = 1'b1;
      uop_offset_d = uop_offset_q + 1'b1;
      uop_last_d   = (mask_rem == '0);
      mask_d       = mask_rem;
      if (mask_rem == '0) state_d = S_IDLE;
      if (cur_opc == 4'b0110) begin
        wa_d    = bit_idx;
        wr_en_d = 1'b1;
      end else begin
        ra2_d   = bit_idx;
        wr_en_d = 1'b0;
      end
    end

    if (in_xfer) begin
      out_valid_d  = 1'b1;
      out_pc_d     = in_pc;
      out_ir_d     = in_ir;
      pc_imm_d     = (opc == 4'b1000) ? in_pc + {{(WIDTH-9){in_ir[8]}}, in_ir[8:0]}
                                      : in_pc + {{(WIDTH-6){in_ir[5]}}, in_ir[5:0]};
      sext_d       = {{(WIDTH-6){in_ir[5]}}, in_ir[5:0]};
      imm970_d     = {in_ir[8:0], {(WIDTH-9){1'b0}}};
      ra1_d        = in_ir[11:9];
      ra2_d        = in_ir[8:6];
      wa_d         = dec_wa;
      wr_en_d      = dec_wr_en;
      uop_last_d   = 1'b1;
      uop_offset_d = '0;
      mask_d       = '0;
      state_d      = S_IDLE;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_d    = dec_illegal;
`else
      illegal_d    = 1'b0;
`endif
      if (is_multi) begin
        uop_last_d = (mask_rem == '0);
        mask_d     = mask_rem;
        state_d    = (mask_rem != '0) ? S_MULTI : S_IDLE;
        // An empty mask still yields a single non-writing micro-op.
        if (in_ir[NREGS-1:0] == '0) begin
          wa_d    = '0;
          wr_en_d = 1'b0;
        end else if (opc == 4'b0110) begin
          wa_d    = bit_idx;
          wr_en_d = 1'b1;
        end else begin
          ra2_d   = bit_idx;
          wa_d    = '0;
          wr_en_d = 1'b0;
        end
      end
    end

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
      mask_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_ir_q     <= '0;
      pc_imm_q     <= '0;
      sext_q       <= '0;
      imm970_q     <= '0;
      ra1_q        <= '0;
      ra2_q        <= '0;
      wa_q         <= '0;
      wr_en_q      <= 1'b0;
      uop_last_q   <= 1'b0;
      uop_offset_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_ir_q     <= out_ir_d;
      pc_imm_q     <= pc_imm_d;
      sext_q       <= sext_d;
      imm970_q     <= imm970_d;
      ra1_q        <= ra1_d;
      ra2_q        <= ra2_d;
      wa_q         <= wa_d;
      wr_en_q      <= wr_en_d;
      uop_last_q   <= uop_last_d;
      uop_offset_q <= uop_offset_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_ir     = out_ir_q;
  assign pc_imm     = pc_imm_q;
  assign sext_out   = sext_q;
  assign imm970     = imm970_q;
  assign ra1        = ra1_q;
  assign ra2        = ra2_q;
  assign wa         = wa_q;
  assign wr_en      = wr_en_q;
  assign uop_last   = uop_last_q;
  assign uop_offset = uop_offset_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal    = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q ^ dec_illegal;
`endif

endmodule
